// File: rtl/motion_est_core_if.sv
// motion_est_core_if
//   Bench-facing motion-estimation interface.
//   start    : level request; high runs a search, low idles/aborts.
//   BestDist : smallest saturated SAD found (all ones = not found).
//   motionX  : two's-complement X offset of the best candidate.
//   motionY  : two's-complement Y offset of the best candidate.
//   done     : high once every candidate has been compared; held until start drops.
//   master modport = requester (bench), slave modport = estimator core.
interface motion_est_core_if #(
    parameter int DIST_W = 8
);
    logic              start;
    logic [DIST_W-1:0] BestDist;
    logic [3:0]        motionX;
    logic [3:0]        motionY;
    logic              done;

    modport master (
        output start,
        input  BestDist, motionX, motionY, done
    );

    modport slave (
        input  start,
        output BestDist, motionX, motionY, done
    );
endinterface

// File: rtl/motion_est_core.sv
// motion_est_core
//   Full-search block matcher: a 16x16 reference block (rmem) is compared
//   against all 256 candidate positions (offsets -8..+7 in X and Y) inside a
//   32x32 search window (smem). Sixteen SAD lanes run in parallel, one per
//   X offset; a Y-offset group of 256 pixels takes 256 clocks. The 16 group
//   results are then scanned one per clock into the best-match registers
//   while the next group accumulates.
//   Ports:
//     clock : system clock, rising edge
//     reset : asynchronous active-high reset
//     me    : motion_est_core_if slave (start / BestDist / motionX / motionY / done)
//   rmem and smem are unreset storage arrays preloaded from outside by hierarchy.
module motion_est_core #(
    parameter int PIX_W  = 8,
    parameter int NUM_PE = 16,
    parameter int DIST_W = 8
) (
    input  logic clock,
    input  logic reset,
    motion_est_core_if.slave me
);
    localparam logic [12:0] LAST_CMP = 13'd4111;

    logic [PIX_W-1:0] rmem [0:255];
    logic [PIX_W-1:0] smem [0:1023];

    logic [12:0]       count_reg;
    logic [DIST_W-1:0] acc_reg    [NUM_PE];
    logic [DIST_W-1:0] sad_sr_reg [NUM_PE];
    logic              cmp_active_reg;
    logic [3:0]        cmp_k_reg;
    logic [3:0]        cmp_g_reg;
    logic [DIST_W-1:0] best_reg;
    logic [3:0]        mx_reg;
    logic [3:0]        my_reg;
    logic              done_reg;

    logic [3:0]        grp;
    logic [7:0]        pix;
    logic [3:0]        row;
    logic [3:0]        col;
    logic              accumulating;
    logic              last_pix;
    logic [PIX_W-1:0]  ref_pix;
    logic [4:0]        win_row;
    logic [DIST_W-1:0] acc_sat [NUM_PE];

    assign grp     = count_reg[11:8];
    assign pix     = count_reg[7:0];
    assign row     = pix[7:4];
    assign col     = pix[3:0];
    assign ref_pix = rmem[pix];

    // Accumulation covers counts 0..4095; bit 12 marks the compare tail.
    assign accumulating = me.start && !done_reg && !count_reg[12];
    assign last_pix     = accumulating && (pix == 8'hFF);

    // 264 + (r+g-8)*32 + (c+k-8) collapses to (r+g)*32 + c + k.
    assign win_row = {1'b0, row} + {1'b0, grp};

    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_pe
        logic [9:0]        addr;
        logic [PIX_W-1:0]  win_pix;
        logic [PIX_W-1:0]  diff;
        logic [DIST_W:0]   sum;

        assign addr    = {win_row, 5'b0} + {6'b0, col} + 10'(gi);
        assign win_pix = smem[addr];
        assign diff    = (ref_pix > win_pix) ? (ref_pix - win_pix) : (win_pix - ref_pix);
        assign sum     = {1'b0, acc_reg[gi]} + (DIST_W+1)'(diff);
        // Saturate instead of wrapping so large SADs never look small.
        assign acc_sat[gi] = sum[DIST_W] ? {DIST_W{1'b1}} : sum[DIST_W-1:0];
    end

    // SAD lanes and the compare shift register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_PE; k++) begin
                acc_reg[k]    <= '0;
                sad_sr_reg[k] <= '0;
            end
        end else if (!me.start) begin
            for (int k = 0; k < NUM_PE; k++) begin
                acc_reg[k] <= '0;
            end
        end else begin
            if (accumulating) begin
                for (int k = 0; k < NUM_PE; k++) begin
                    acc_reg[k] <= last_pix ? '0 : acc_sat[k];
                end
            end
            if (last_pix) begin
                for (int k = 0; k < NUM_PE; k++) begin
                    sad_sr_reg[k] <= acc_sat[k];
                end
            end else if (cmp_active_reg) begin
                for (int k = 0; k < NUM_PE - 1; k++) begin
                    sad_sr_reg[k] <= sad_sr_reg[k+1];
                end
                sad_sr_reg[NUM_PE-1] <= {DIST_W{1'b1}};
            end
        end
    end

    // Controller and best-match tracking.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg      <= '0;
            done_reg       <= 1'b0;
            cmp_active_reg <= 1'b0;
            cmp_k_reg      <= '0;
            cmp_g_reg      <= '0;
            best_reg       <= {DIST_W{1'b1}};
            mx_reg         <= '0;
            my_reg         <= '0;
        end else if (!me.start) begin
            // Abort/idle: outputs keep their last values, pipeline drops.
            count_reg      <= '0;
            done_reg       <= 1'b0;
            cmp_active_reg <= 1'b0;
        end else begin
            if (!done_reg) begin
                count_reg <= count_reg + 13'd1;
                if (count_reg == LAST_CMP) begin
                    done_reg <= 1'b1;
                end
                if (count_reg == '0) begin
                    best_reg <= {DIST_W{1'b1}};
                end
            end
            if (last_pix) begin
                cmp_active_reg <= 1'b1;
                cmp_k_reg      <= '0;
                cmp_g_reg      <= grp;
            end else if (cmp_active_reg) begin
                // Strict less-than keeps the earliest candidate on ties.
                if (sad_sr_reg[0] < best_reg) begin
                    best_reg <= sad_sr_reg[0];
                    mx_reg   <= cmp_k_reg ^ 4'h8;   // k-8 in 4-bit two's complement
                    my_reg   <= cmp_g_reg ^ 4'h8;
                end
                cmp_k_reg <= cmp_k_reg + 4'd1;
                if (cmp_k_reg == 4'hF) begin
                    cmp_active_reg <= 1'b0;
                end
            end
        end
    end

    assign me.BestDist = best_reg;
    assign me.motionX  = mx_reg;
    assign me.motionY  = my_reg;
    assign me.done     = done_reg;
endmodule

// File: tb/tb_motion_est_core.sv
module tb_motion_est_core;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    motion_est_core_if #(.DIST_W(8)) me ();

    motion_est_core dut (
        .clock (clock),
        .reset (reset),
        .me    (me.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Random search window.
    task automatic load_random_window();
        for (int i = 0; i < 1024; i++) dut.smem[i] = 8'($urandom_range(0, 255));
    endtask

    // Reference block copied out of the window at offset (dx,dy).
    task automatic load_ref(input int dx, input int dy);
        for (int i = 0; i < 256; i++)
            dut.rmem[i] = dut.smem[264 + (i / 16 + dy) * 32 + (i % 16 + dx)];
    endtask

    // Raise start, confirm done stays low through 4111 clocks and rises on 4112.
    task automatic run_search(input string tag);
        me.start = 1'b1;
        repeat (4111) @(negedge clock);
        chk({tag, "_done_early"}, {31'b0, me.done}, 32'd0);
        @(negedge clock);
        chk({tag, "_done"}, {31'b0, me.done}, 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [7:0] bd,
                                input logic [3:0] mx, input logic [3:0] my);
        chk({tag, "_bestdist"}, {24'b0, me.BestDist}, {24'b0, bd});
        chk({tag, "_motionx"},  {28'b0, me.motionX},  {28'b0, mx});
        chk({tag, "_motiony"},  {28'b0, me.motionY},  {28'b0, my});
        $display("txn %s: BestDist=%0h motionX=%0h motionY=%0h done=%0b",
                 tag, me.BestDist, me.motionX, me.motionY, me.done);
    endtask

    task automatic stop_search();
        me.start = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        me.start = 1'b0;
        reset    = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Reset state
        check_result("reset", 8'hFF, 4'h0, 4'h0);
        chk("reset_done", {31'b0, me.done}, 32'd0);

        // No match: every SAD saturates, motion keeps reset values
        for (int i = 0; i < 1024; i++) dut.smem[i] = 8'hFF;
        for (int i = 0; i < 256; i++)  dut.rmem[i] = 8'h00;
        run_search("nomatch");
        check_result("nomatch", 8'hFF, 4'h0, 4'h0);
        stop_search();
        chk("stop_done_low", {31'b0, me.done}, 32'd0);

        // Tie: all SADs zero, first candidate (-8,-8) wins
        for (int i = 0; i < 1024; i++) dut.smem[i] = 8'h10;
        for (int i = 0; i < 256; i++)  dut.rmem[i] = 8'h10;
        run_search("tie");
        check_result("tie", 8'h00, 4'h8, 4'h8);
        stop_search();

        // Exact match at (3,-5)
        load_random_window();
        load_ref(3, -5);
        run_search("exact");
        check_result("exact", 8'h00, 4'h3, 4'hB);
        stop_search();

        // Corner (-8,-8)
        load_ref(-8, -8);
        run_search("corner_lo");
        check_result("corner_lo", 8'h00, 4'h8, 4'h8);
        stop_search();

        // Corner (7,7)
        load_ref(7, 7);
        run_search("corner_hi");
        check_result("corner_hi", 8'h00, 4'h7, 4'h7);
        stop_search();

        // Reset mid-search at count 2000
        load_ref(3, -5);
        me.start = 1'b1;
        repeat (2000) @(negedge clock);
        chk("midrun_count", {19'b0, dut.count_reg}, 32'd2000);
        reset = 1'b1;
        #1;
        check_result("midreset", 8'hFF, 4'h0, 4'h0);
        chk("midreset_done", {31'b0, me.done}, 32'd0);
        me.start = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run_search("after_reset");
        check_result("after_reset", 8'h00, 4'h3, 4'hB);
        stop_search();

        // Abort at count 1000 then restart, exact match at (-2,4)
        load_ref(-2, 4);
        me.start = 1'b1;
        repeat (1000) @(negedge clock);
        chk("abort_count", {19'b0, dut.count_reg}, 32'd1000);
        me.start = 1'b0;
        @(negedge clock);
        chk("abort_count_clr", {19'b0, dut.count_reg}, 32'd0);
        chk("abort_done", {31'b0, me.done}, 32'd0);
        run_search("restart");
        check_result("restart", 8'h00, 4'hE, 4'h4);
        stop_search();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
